// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, defaults and helpers for the round sequencer
//
// Contents:
//   state_e          sequencer state enum (IDLE, COUNT, PLAY, GAP, DONE)
//   *_DEF constants  default countdown steps, play-window ticks and rounds
//   sat_inc()        increment that sticks at a supplied ceiling
package game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      PLAY,
      GAP,
      DONE
   } state_e;

   localparam int CD_STEPS_DEF   = 4;
   localparam int PLAY_TICKS_DEF = 10;
   localparam int ROUNDS_DEF     = 3;

   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value);
      return (value >= max_value) ? max_value : value + 32'd1;
   endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - tick-enabled up-counter with clear and registered terminal flag
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   clr_i   synchronous clear to zero (wins over en_i)
//   en_i    count enable (one-cycle tick)
//   cnt_o   current count, holds once it reaches TERM
//   term_o  registered flag, high while cnt_o == TERM
module tick_counter #(
   parameter int W    = 4,
   parameter int TERM = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         term_o
);

   localparam logic [W-1:0] TERM_V = W'(TERM);

   logic [W-1:0] cnt_q, cnt_d;
   logic         term_q, term_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !term_q) begin
         cnt_d = cnt_q + W'(1);
      end
      // Flag is computed from the next count so it is valid in the same
      // cycle the count lands on TERM, including straight after a clear.
      term_d = (cnt_d == TERM_V);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         term_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         term_q <= term_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign term_o = term_q;

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - multi-round reaction game sequencer (countdown, play window, scoring)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   tick         one-cycle timebase enable
//   start        one-cycle start pulse (honoured in IDLE and DONE only)
//   hit          one-cycle player-hit pulse (counted in PLAY only)
//   cd_step      current countdown step
//   cd_active    high while the countdown runs
//   play_active  high while the play window is open
//   round_done   one-cycle pulse at the end of each play window
//   match_done   high from the end of the final round until restart
//   round_idx    current round, 0-based
//   score        saturating hit count for the match
module round_sequencer
   import game_pkg::*;
#(
   parameter int CD_STEPS   = CD_STEPS_DEF,
   parameter int PLAY_TICKS = PLAY_TICKS_DEF,
   parameter int ROUNDS     = ROUNDS_DEF,
   parameter int SCORE_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tick,
   input  logic                        start,
   input  logic                        hit,
   output logic [$clog2(CD_STEPS)-1:0] cd_step,
   output logic                        cd_active,
   output logic                        play_active,
   output logic                        round_done,
   output logic                        match_done,
   output logic [1:0]                  round_idx,
   output logic [SCORE_W-1:0]          score
);

   localparam int CD_W = $clog2(CD_STEPS);
   localparam int PC_W = $clog2(PLAY_TICKS) + 1;
   localparam logic [1:0]         LAST_ROUND = 2'(ROUNDS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   state_e state_q, state_d;

   logic [1:0]         round_q, round_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               cd_active_q, cd_active_d;
   logic               play_active_q, play_active_d;
   logic               round_done_q, round_done_d;
   logic               match_done_q, match_done_d;

   logic [CD_W-1:0] cd_cnt;
   logic            cd_term;
   logic [PC_W-1:0] play_cnt;
   logic            play_term;

   logic start_match;
   logic cd_last;
   logic play_last;
   logic gap_done;

   // Transition qualifiers, all decoded from registered state.
   assign start_match = start && ((state_q == IDLE) || (state_q == DONE));
   assign cd_last     = tick && (state_q == COUNT) && cd_term;
   assign play_last   = tick && (state_q == PLAY) && play_term;
   assign gap_done    = tick && (state_q == GAP);

   // Countdown step: cleared whenever COUNT is entered, stops at its last
   // step so cd_step keeps showing the final digit through PLAY/GAP/DONE.
   tick_counter #(
      .W    (CD_W),
      .TERM (CD_STEPS - 1)
   ) u_cd_counter (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (start_match || gap_done),
      .en_i   (tick && (state_q == COUNT)),
      .cnt_o  (cd_cnt),
      .term_o (cd_term)
   );

   // Play window: cleared on the edge that enters PLAY.
   tick_counter #(
      .W    (PC_W),
      .TERM (PLAY_TICKS - 1)
   ) u_play_counter (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (cd_last),
      .en_i   (tick && (state_q == PLAY)),
      .cnt_o  (play_cnt),
      .term_o (play_term)
   );

   // Window position is consumed through the terminal flag only.
   logic unused_play_cnt;
   assign unused_play_cnt = ^play_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         round_q       <= '0;
         score_q       <= '0;
         cd_active_q   <= 1'b0;
         play_active_q <= 1'b0;
         round_done_q  <= 1'b0;
         match_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         round_q       <= round_d;
         score_q       <= score_d;
         cd_active_q   <= cd_active_d;
         play_active_q <= play_active_d;
         round_done_q  <= round_done_d;
         match_done_q  <= match_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_match) state_d = COUNT;
         COUNT:   if (cd_last)     state_d = PLAY;
         PLAY:    if (play_last)   state_d = (round_q == LAST_ROUND) ? DONE : GAP;
         GAP:     if (gap_done)    state_d = COUNT;
         DONE:    if (start_match) state_d = COUNT;
         default:                  state_d = IDLE;
      endcase
   end

   // Registered outputs are loaded from the next state so they change on
   // the same edge as the state they describe.
   always_comb begin
      cd_active_d   = (state_d == COUNT);
      play_active_d = (state_d == PLAY);
      match_done_d  = (state_d == DONE);
      round_done_d  = play_last;

      round_d = round_q;
      if (start_match) begin
         round_d = '0;
      end else if (gap_done) begin
         round_d = round_q + 2'd1;
      end

      score_d = score_q;
      if (start_match) begin
         score_d = '0;
      end else if ((state_q == PLAY) && hit) begin
         score_d = SCORE_W'(sat_inc(32'(score_q), 32'(SCORE_MAX)));
      end
   end

   assign cd_step     = cd_cnt;
   assign cd_active   = cd_active_q;
   assign play_active = play_active_q;
   assign round_done  = round_done_q;
   assign match_done  = match_done_q;
   assign round_idx   = round_q;
   assign score       = score_q;

endmodule
